// File: rtl/dot_accumulator.sv
// Aligns an operand-side valid/last tag with a fixed-latency upstream psum and accumulates a dot product.
// Optional DOT_ACC_SAT_EN: unsigned saturating accumulation plus a res_sat output flag.
module dot_accumulator #(
   parameter int LAT   = 2,
   parameter int ACC_W = 40,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   input  logic             op_last,
   output logic             in_ready,
   input  logic [31:0]      psum,
   output logic [ACC_W-1:0] res_data,
   output logic [CNT_W-1:0] res_count,
   output logic             res_valid,
`ifdef DOT_ACC_SAT_EN
   output logic             res_sat,
`endif
   input  logic             res_ready
);

   logic [LAT-1:0]   vld_q, vld_d;
   logic [LAT-1:0]   last_q, last_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] res_data_q, res_data_d;
   logic [CNT_W-1:0] res_count_q, res_count_d;
   logic             res_valid_q, res_valid_d;
   logic             accept;
   logic [ACC_W-1:0] sum;
   logic             arrive;
   logic             arrive_last;
`ifdef DOT_ACC_SAT_EN
   logic [ACC_W:0]   sum_ext;
   logic             clamp;
   logic             sat_q, sat_d;
   logic             res_sat_q, res_sat_d;
`endif

   // A pending result or an in-flight last term blocks new terms, since upstream cannot stall.
   assign in_ready = !reset && !res_valid_q && !(|last_q);
   assign accept   = op_valid && in_ready;

   assign arrive      = vld_q[LAT-1];
   assign arrive_last = last_q[LAT-1];

`ifdef DOT_ACC_SAT_EN
   assign sum_ext = {1'b0, acc_q} + (ACC_W+1)'(psum);
   assign clamp   = sum_ext[ACC_W];
   assign sum     = clamp ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
   assign sum     = acc_q + ACC_W'(psum);
`endif

   always_comb begin
      vld_d       = '0;
      last_d      = '0;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      res_data_d  = res_data_q;
      res_count_d = res_count_q;
      res_valid_d = res_valid_q;
`ifdef DOT_ACC_SAT_EN
      sat_d       = sat_q;
      res_sat_d   = res_sat_q;
`endif

      vld_d[0]  = accept;
      last_d[0] = accept && op_last;
      for (int i = 1; i < LAT; i++) begin
         vld_d[i]  = vld_q[i-1];
         last_d[i] = last_q[i-1];
      end

      if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end

      if (arrive) begin
         if (arrive_last) begin
            res_data_d  = sum;
            res_count_d = cnt_q + CNT_W'(1);
            res_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
`ifdef DOT_ACC_SAT_EN
            res_sat_d   = sat_q || clamp;
            sat_d       = 1'b0;
`endif
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
`ifdef DOT_ACC_SAT_EN
            sat_d = sat_q || clamp;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q       <= '0;
         last_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         res_data_q  <= '0;
         res_count_q <= '0;
         res_valid_q <= 1'b0;
`ifdef DOT_ACC_SAT_EN
         sat_q       <= 1'b0;
         res_sat_q   <= 1'b0;
`endif
      end else begin
         vld_q       <= vld_d;
         last_q      <= last_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         res_data_q  <= res_data_d;
         res_count_q <= res_count_d;
         res_valid_q <= res_valid_d;
`ifdef DOT_ACC_SAT_EN
         sat_q       <= sat_d;
         res_sat_q   <= res_sat_d;
`endif
      end
   end

   assign res_data  = res_data_q;
   assign res_count = res_count_q;
   assign res_valid = res_valid_q;
`ifdef DOT_ACC_SAT_EN
   assign res_sat   = res_sat_q;
`endif

endmodule

// File: tb/tb_dot_accumulator.sv
// Randomized bench for dot_accumulator with an upstream latency model and a sum-of-terms reference.
// Build with or without DOT_ACC_SAT_EN.
module tb_dot_accumulator;

   localparam int LAT   = 2;
   localparam int ACC_W = 34;
   localparam int CNT_W = 4;
   localparam longint unsigned MAXV = (64'd1 << ACC_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             op_valid;
   logic             op_last;
   logic             in_ready;
   logic [31:0]      psum;
   logic [ACC_W-1:0] res_data;
   logic [CNT_W-1:0] res_count;
   logic             res_valid;
   logic             res_ready;
   logic             res_sat;

   logic [31:0] c_in;
   logic [31:0] pipe [LAT];
   int          rr_mode;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      longint unsigned data;
      int              cnt;
      bit              sat;
      int              due;
   } exp_t;

   exp_t expq[$];

   dot_accumulator #(.LAT(LAT), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .op_valid  (op_valid),
      .op_last   (op_last),
      .in_ready  (in_ready),
      .psum      (psum),
      .res_data  (res_data),
      .res_count (res_count),
      .res_valid (res_valid),
`ifdef DOT_ACC_SAT_EN
      .res_sat   (res_sat),
`endif
      .res_ready (res_ready)
   );

`ifndef DOT_ACC_SAT_EN
   assign res_sat = 1'b0;
`endif

   always #5 clk = ~clk;

   // Upstream multiply-add stage: C of the operands captured at an edge appears LAT edges later.
   always @(posedge clk) begin
      pipe[0] <= c_in;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign psum = pipe[LAT-1];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: result is the plain sum of the C values of accepted terms.
   int              cyc = 0;
   longint unsigned cur_sum = 0;
   int              cur_n = 0;
   bit              prev_valid = 0;
   bit              prev_reset = 0;
   bit              hold = 0;
   logic [63:0]     hold_data, hold_cnt;

   initial begin
      forever begin
         @(negedge clk);
         #4;
         cyc++;
         if (reset) begin
            check("in_ready_rst", in_ready, 0);
            expq.delete();
            cur_sum = 0;
            cur_n = 0;
            hold = 0;
            prev_valid = 0;
            prev_reset = 1;
            continue;
         end
         if (prev_reset) begin
            check("rst_valid", res_valid, 0);
            check("rst_data", res_data, 0);
            check("rst_count", res_count, 0);
         end
         prev_reset = 0;
         check("in_ready", in_ready, expq.size() == 0);
         if (expq.size() > 0 && cyc == expq[0].due)
            check("res_valid_due", res_valid, 1);
         if (res_valid) begin
            check("spurious_valid", res_valid, expq.size() != 0);
            if (expq.size() > 0) begin
               if (!prev_valid) check("latency", cyc, expq[0].due);
               if (hold) begin
                  check("hold_data", res_data, hold_data);
                  check("hold_count", res_count, hold_cnt);
               end
               if (res_ready) begin
                  check("res_data", res_data, expq[0].data);
                  check("res_count", res_count, expq[0].cnt);
`ifdef DOT_ACC_SAT_EN
                  check("res_sat", res_sat, expq[0].sat);
`endif
                  void'(expq.pop_front());
               end
            end
         end
         hold = res_valid && !res_ready;
         hold_data = res_data;
         hold_cnt = res_count;
         prev_valid = res_valid;
         if (op_valid && in_ready) begin
            cur_sum += c_in;
            cur_n++;
            if (op_last) begin
               exp_t e;
`ifdef DOT_ACC_SAT_EN
               e.sat = cur_sum > MAXV;
               e.data = e.sat ? MAXV : cur_sum;
`else
               e.sat = 0;
               e.data = cur_sum & MAXV;
`endif
               e.cnt = cur_n % (1 << CNT_W);
               e.due = cyc + LAT + 1;
               expq.push_back(e);
               cur_sum = 0;
               cur_n = 0;
            end
         end
      end
   end

   initial begin
      res_ready = 0;
      forever begin
         @(negedge clk);
         case (rr_mode)
            0:       res_ready = ($urandom_range(0, 2) != 0);
            1:       res_ready = 1'b1;
            default: res_ready = 1'b0;
         endcase
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         op_valid = 0;
         op_last = 1'($urandom);
         c_in = $urandom;
         @(negedge clk);
      end
   endtask

   task automatic send_term(input logic [31:0] c, input bit last);
      int w;
      w = 0;
      op_valid = 1;
      op_last = last;
      c_in = c;
      #4;
      while (!in_ready && w < 300) begin
         @(negedge clk);
         #4;
         w++;
      end
      if (w >= 300) check("accept_timeout", in_ready, 1);
      @(negedge clk);
      op_valid = 0;
      op_last = 1'($urandom);
      c_in = $urandom;
   endtask

   task automatic do_reset(input int n);
      reset = 1;
      op_valid = 0;
      repeat (n) @(negedge clk);
      reset = 0;
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while ((expq.size() != 0 || res_valid) && w < 400) begin
         @(negedge clk);
         w++;
      end
      check("drain", expq.size(), 0);
   endtask

   initial begin
      int len;
      bit abort, big;
      int w;
      reset = 1;
      op_valid = 0;
      op_last = 0;
      c_in = 0;
      rr_mode = 1;
      @(negedge clk);
      do_reset(3);
      idle(2);

      // T1
      send_term(6, 0);
      send_term(20, 0);
      send_term(42, 1);
      wait_drain();
      idle(2);

      // T2
      send_term(32'hFFFFFFFF, 1);
      wait_drain();
      idle(1);

      // T3: result stalled 5 cycles while the next vector waits
      rr_mode = 2;
      send_term(6, 0);
      send_term(20, 0);
      fork
         begin
            w = 0;
            while (!res_valid && w < 50) begin
               @(negedge clk);
               w++;
            end
            repeat (5) @(negedge clk);
            rr_mode = 1;
         end
         begin
            send_term(42, 1);
            send_term(3, 0);
            send_term(4, 1);
         end
      join
      wait_drain();
      idle(1);

      // T4: reset mid-vector
      send_term(100, 0);
      send_term(200, 0);
      do_reset(1);
      idle(4);
      send_term(5, 0);
      send_term(7, 1);
      wait_drain();

      // T5: wrap (or clamp) at ACC_W=34
      for (int i = 0; i < 5; i++) send_term(32'hFFFFFFFF, i == 4);
      wait_drain();

      // T6
      send_term(11, 0);
      send_term(13, 1);
      send_term(17, 1);
      wait_drain();

      // Random vectors, bubbles, back-pressure and occasional aborts
      rr_mode = 0;
      for (int v = 0; v < 40; v++) begin
         len = $urandom_range(1, 20);
         abort = ($urandom_range(0, 9) == 0);
         big = ($urandom_range(0, 2) == 0);
         for (int t = 0; t < len; t++) begin
            send_term(big ? 32'hFFFFFFFF - $urandom_range(0, 3) : $urandom,
                      t == len - 1);
            if (abort && t == len / 2 && t != len - 1) begin
               do_reset(1);
               break;
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
      end
      rr_mode = 1;
      wait_drain();
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
